// File: rtl/uart_tx_mmio.sv
// rtl/uart_tx_mmio.sv - memory-mapped 8N1 UART transmitter with TX FIFO and drain interrupt
module uart_tx_mmio #(
    parameter logic [63:0] BASE_ADDR    = 64'h8000_0000,
    parameter int          CLKS_PER_BIT = 434,
    parameter int          FIFO_DEPTH   = 16
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [63:0] bus_address,
    input  logic [63:0] bus_write_data,
    input  logic        bus_write_enable,
    input  logic        bus_read_enable,
    output logic [63:0] bus_read_data,
    input  logic        interrupt_ack,
    output logic [3:0]  interrupt_vector,
    output logic        uart_txd
);
    localparam int PW   = $clog2(FIFO_DEPTH);
    localparam int CNTW = PW + 1;
    localparam int BW   = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [BW-1:0]   BAUD_MAX = BW'(CLKS_PER_BIT - 1);
    localparam logic [CNTW-1:0] DEPTH    = CNTW'(FIFO_DEPTH);

    typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

    state_t          state, state_n;
    logic [BW-1:0]   baud_cnt, baud_cnt_n;
    logic [2:0]      bit_idx, bit_idx_n;
    logic [7:0]      shifter, shifter_n;
    logic            txd_n;
    logic            pop;
    logic            frame_end;

    logic [7:0]      mem [FIFO_DEPTH];
    logic [PW-1:0]   wr_ptr, rd_ptr;
    logic [CNTW-1:0] count;

    logic            irq_en, tx_done, overflow, irq_q;
    logic            hit;
    logic [4:0]      offset;
    logic            wr_txdata, wr_status, wr_ctrl;
    logic            push, accept, drop;
    logic [63:0]     status_word, rdata_n;
    logic            unused_bits;

    assign hit       = (bus_address[63:5] == BASE_ADDR[63:5]);
    assign offset    = bus_address[4:0];
    assign wr_txdata = bus_write_enable && hit && (offset == 5'h00);
    assign wr_status = bus_write_enable && hit && (offset == 5'h08);
    assign wr_ctrl   = bus_write_enable && hit && (offset == 5'h10);
    assign unused_bits = ^bus_write_data[63:8];

    // A pop in the same cycle frees a slot, so a full FIFO can still accept.
    assign push   = wr_txdata;
    assign accept = push && ((count < DEPTH) || pop);
    assign drop   = push && !accept;

    always_comb begin
        status_word       = '0;
        status_word[0]    = (state != IDLE);
        status_word[1]    = (count == DEPTH);
        status_word[2]    = (count == '0);
        status_word[3]    = tx_done;
        status_word[4]    = overflow;
        status_word[12:8] = 5'(count);
    end

    always_comb begin
        rdata_n = '0;
        case (offset)
            5'h08:   rdata_n = status_word;
            5'h10:   rdata_n = {63'd0, irq_en};
            default: rdata_n = '0;
        endcase
    end

    always_comb begin
        state_n    = state;
        baud_cnt_n = baud_cnt;
        bit_idx_n  = bit_idx;
        shifter_n  = shifter;
        pop        = 1'b0;
        frame_end  = 1'b0;
        case (state)
            IDLE: begin
                if (count != '0) begin
                    pop        = 1'b1;
                    shifter_n  = mem[rd_ptr];
                    baud_cnt_n = BAUD_MAX;
                    state_n    = START;
                end
            end
            START: begin
                if (baud_cnt == '0) begin
                    baud_cnt_n = BAUD_MAX;
                    bit_idx_n  = 3'd0;
                    state_n    = DATA;
                end else begin
                    baud_cnt_n = baud_cnt - 1'b1;
                end
            end
            DATA: begin
                if (baud_cnt == '0) begin
                    baud_cnt_n = BAUD_MAX;
                    if (bit_idx == 3'd7) begin
                        state_n = STOP;
                    end else begin
                        bit_idx_n = bit_idx + 3'd1;
                    end
                end else begin
                    baud_cnt_n = baud_cnt - 1'b1;
                end
            end
            STOP: begin
                if (baud_cnt == '0) begin
                    baud_cnt_n = '0;
                    state_n    = IDLE;
                    frame_end  = 1'b1;
                end else begin
                    baud_cnt_n = baud_cnt - 1'b1;
                end
            end
            default: state_n = IDLE;
        endcase

        // Line level follows the state being entered so uart_txd is a clean flop output.
        case (state_n)
            START:   txd_n = 1'b0;
            DATA:    txd_n = shifter_n[bit_idx_n];
            default: txd_n = 1'b1;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state    <= IDLE;
            baud_cnt <= '0;
            bit_idx  <= '0;
            shifter  <= '0;
            uart_txd <= 1'b1;
        end else begin
            state    <= state_n;
            baud_cnt <= baud_cnt_n;
            bit_idx  <= bit_idx_n;
            shifter  <= shifter_n;
            uart_txd <= txd_n;
        end
    end

    always_ff @(posedge clk) begin
        if (accept) begin
            mem[wr_ptr] <= bus_write_data[7:0];
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            wr_ptr        <= '0;
            rd_ptr        <= '0;
            count         <= '0;
            overflow      <= 1'b0;
            tx_done       <= 1'b0;
            irq_en        <= 1'b0;
            irq_q         <= 1'b0;
            bus_read_data <= '0;
        end else begin
            if (accept) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({accept, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase

            if (drop) begin
                overflow <= 1'b1;
            end else if (wr_status && bus_write_data[4]) begin
                overflow <= 1'b0;
            end

            // Burst is drained only if nothing new arrives as the last stop bit ends.
            if (frame_end && (count == '0) && !push) begin
                tx_done <= 1'b1;
            end else if ((wr_status && bus_write_data[3]) || interrupt_ack) begin
                tx_done <= 1'b0;
            end

            if (wr_ctrl) begin
                irq_en <= bus_write_data[0];
            end
            irq_q <= irq_en && tx_done;

            if (bus_read_enable && hit) begin
                bus_read_data <= rdata_n;
            end
        end
    end

    assign interrupt_vector = {3'b000, irq_q};
endmodule

// File: tb/tb_uart_tx_mmio.sv
// tb/tb_uart_tx_mmio.sv - directed self-checking bench for uart_tx_mmio
module tb_uart_tx_mmio;
    localparam logic [63:0] A_TX     = 64'h8000_0000;
    localparam logic [63:0] A_STATUS = 64'h8000_0008;
    localparam logic [63:0] A_CTRL   = 64'h8000_0010;

    logic        clk;
    logic        reset;
    logic [63:0] bus_address;
    logic [63:0] bus_write_data;
    logic        bus_write_enable;
    logic        bus_read_enable;
    logic [63:0] bus_read_data;
    logic        interrupt_ack;
    logic [3:0]  interrupt_vector;
    logic        uart_txd;

    int n_cmp = 0;
    int n_err = 0;
    logic [63:0] rd;

    uart_tx_mmio #(
        .BASE_ADDR(64'h8000_0000),
        .CLKS_PER_BIT(4),
        .FIFO_DEPTH(16)
    ) dut (
        .clk(clk),
        .reset(reset),
        .bus_address(bus_address),
        .bus_write_data(bus_write_data),
        .bus_write_enable(bus_write_enable),
        .bus_read_enable(bus_read_enable),
        .bus_read_data(bus_read_data),
        .interrupt_ack(interrupt_ack),
        .interrupt_vector(interrupt_vector),
        .uart_txd(uart_txd)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic bus_write(input logic [63:0] addr, input logic [63:0] data);
        bus_address      = addr;
        bus_write_data   = data;
        bus_write_enable = 1'b1;
        tick();
        bus_write_enable = 1'b0;
    endtask

    task automatic bus_read(input logic [63:0] addr, output logic [63:0] data);
        bus_address     = addr;
        bus_read_enable = 1'b1;
        tick();
        bus_read_enable = 1'b0;
        data = bus_read_data;
    endtask

    function automatic logic frame_bit(input logic [7:0] b, input int i);
        int slot;
        slot = i / 4;
        if (slot == 0) return 1'b0;
        if (slot == 9) return 1'b1;
        return b[slot-1];
    endfunction

    // Checks sample indices first..39 of a frame, ticking after each; ends on the following cycle.
    task automatic expect_frame(input string tag, input logic [7:0] b, input int first);
        for (int i = first; i < 40; i++) begin
            check(tag, 64'(uart_txd), 64'(frame_bit(b, i)));
            tick();
        end
    endtask

    initial begin
        reset = 1'b0;
        bus_address = '0;
        bus_write_data = '0;
        bus_write_enable = 1'b0;
        bus_read_enable = 1'b0;
        interrupt_ack = 1'b0;

        // Reset state
        tick(); tick(); tick();
        check("rst_txd", 64'(uart_txd), 64'd1);
        check("rst_rdata", bus_read_data, 64'd0);
        check("rst_irq", 64'(interrupt_vector), 64'd0);
        reset = 1'b1;
        for (int i = 0; i < 100; i++) tick();
        check("idle_txd", 64'(uart_txd), 64'd1);
        check("idle_irq", 64'(interrupt_vector), 64'd0);
        bus_read(A_STATUS, rd);
        check("idle_status", rd, 64'h4);
        bus_read(A_CTRL, rd);
        check("idle_ctrl", rd, 64'h0);

        // Single frame 0x41 with busy tracked through a continuous STATUS read
        bus_write(A_TX, 64'h41);
        check("f41_idle", 64'(uart_txd), 64'd1);
        bus_address = A_STATUS;
        bus_read_enable = 1'b1;
        for (int i = 0; i < 40; i++) begin
            tick();
            check("f41_txd", 64'(uart_txd), 64'(frame_bit(8'h41, i)));
            if (i >= 1) check("f41_busy", 64'(bus_read_data[0]), 64'd1);
        end
        tick();
        check("f41_end_txd", 64'(uart_txd), 64'd1);
        check("f41_end_busy", 64'(bus_read_data[0]), 64'd1);
        tick();
        check("f41_done_status", bus_read_data, 64'hC);
        bus_read_enable = 1'b0;
        bus_write(A_STATUS, 64'h8);
        bus_read(A_STATUS, rd);
        check("txdone_w1c", rd, 64'h4);

        // Interrupt on drain of a three-byte burst
        bus_write(A_CTRL, 64'h1);
        bus_read(A_CTRL, rd);
        check("ctrl_rd", rd, 64'h1);
        bus_read(64'h7FFF_FFF0, rd);
        check("miss_rd_hold", rd, 64'h1);
        bus_write(A_TX, 64'h55);
        check("b1_idle", 64'(uart_txd), 64'd1);
        bus_write(A_TX, 64'hA3);
        check("b1_start", 64'(uart_txd), 64'd0);
        bus_write(A_TX, 64'h0F);
        expect_frame("b1_frame", 8'h55, 1);
        check("b1_gap", 64'(uart_txd), 64'd1);
        tick();
        expect_frame("b2_frame", 8'hA3, 0);
        check("b2_gap", 64'(uart_txd), 64'd1);
        tick();
        expect_frame("b3_frame", 8'h0F, 0);
        check("b3_end_txd", 64'(uart_txd), 64'd1);
        check("b3_irq_latency", 64'(interrupt_vector), 64'd0);
        bus_read(A_STATUS, rd);
        check("b3_status", rd, 64'hC);
        check("b3_irq", 64'(interrupt_vector), 64'd1);
        interrupt_ack = 1'b1;
        tick();
        interrupt_ack = 1'b0;
        tick();
        check("ack_irq", 64'(interrupt_vector), 64'd0);
        bus_read(A_STATUS, rd);
        check("ack_status", rd, 64'h4);

        // Read and write of CTRL in the same cycle returns the pre-write value
        bus_address      = A_CTRL;
        bus_write_data   = 64'h0;
        bus_write_enable = 1'b1;
        bus_read_enable  = 1'b1;
        tick();
        bus_write_enable = 1'b0;
        bus_read_enable  = 1'b0;
        check("rw_same_cycle", bus_read_data, 64'h1);
        bus_read(A_CTRL, rd);
        check("ctrl_cleared", rd, 64'h0);

        // Overflow: 18 pushes while the transmitter is mid-frame
        bus_write(A_TX, 64'h11);
        tick();
        for (int i = 0; i < 18; i++) bus_write(A_TX, 64'(i));
        bus_read(A_STATUS, rd);
        check("ovf_status", rd, 64'h1013);
        bus_write(A_STATUS, 64'h10);
        bus_read(A_STATUS, rd);
        check("ovf_w1c", rd, 64'h1003);
        reset = 1'b0;
        tick(); tick();
        reset = 1'b1;
        bus_read(A_STATUS, rd);
        check("ovf_reset_status", rd, 64'h4);

        // Address misses
        bus_write(64'h8000_0100, 64'h99);
        bus_write(64'h7FFF_FFE0, 64'h99);
        bus_write(64'h7FFF_FFF0, 64'h1);
        for (int i = 0; i < 4; i++) begin
            tick();
            check("miss_txd", 64'(uart_txd), 64'd1);
        end
        bus_read(A_STATUS, rd);
        check("miss_status", rd, 64'h4);
        bus_read(64'h8000_0018, rd);
        check("rsvd_rd", rd, 64'h0);
        bus_read(A_CTRL, rd);
        check("miss_ctrl", rd, 64'h0);
        bus_read(A_STATUS, rd);
        bus_read(A_TX, rd);
        check("txdata_rd", rd, 64'h0);

        // Reset in the middle of DATA bit 3 of 0xA5
        bus_write(A_TX, 64'hA5);
        for (int i = 0; i < 14; i++) tick();
        check("a5_bit2", 64'(uart_txd), 64'd1);
        for (int i = 0; i < 4; i++) tick();
        check("a5_bit3", 64'(uart_txd), 64'd0);
        reset = 1'b0;
        tick();
        check("midrst_txd", 64'(uart_txd), 64'd1);
        check("midrst_irq", 64'(interrupt_vector), 64'd0);
        reset = 1'b1;
        bus_read(A_STATUS, rd);
        check("midrst_status", rd, 64'h4);
        for (int i = 0; i < 6; i++) begin
            tick();
            check("midrst_quiet", 64'(uart_txd), 64'd1);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
